// File: rtl/i2c_target_os.sv
// I2C target on the system clock: synchronised and glitch-filtered SCL/SDA,
// open-drain SDA drive, and a register-pointer interface with auto-increment.
module i2c_target_os #(
   parameter logic [6:0] TGT_ADDR    = 7'h5A,
   parameter int         REG_AW      = 8,
   parameter int         FILT        = 3,
   parameter int         SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic [REG_AW-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   input  logic [7:0]        reg_rdata,
   output logic              reg_re,
   output logic              busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_ADDR, WR_PTR, ACK_PTR, WR_DATA, ACK_DATA, RD, RD_ACK, WAIT_P
   } state_t;

   localparam logic [2:0]        FILT_M1  = 3'(FILT - 1);
   localparam logic [REG_AW-1:0] ADDR_ONE = REG_AW'(1);

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic [1:0]             raw_s, lvl, lvl_p1;
   logic [1:0][2:0]        fcnt;

   logic       scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
   logic [7:0] shift, rx_byte;
   logic [2:0] cnt;
   logic       ack_ph, rw, mack_n;

   logic shift_in, ack_begin, ack_end, rd_load, rd_shift, rd_done, ptr_load, wr_strobe;

   // Stage p0: synchronisers; the bus idles high, so reset to 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      end
   end

   assign raw_s = {sda_sync[SYNC_STAGES-1], scl_sync[SYNC_STAGES-1]};

   // Stage p1: a new level is accepted only after FILT consecutive samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl    <= 2'b11;
         lvl_p1 <= 2'b11;
         fcnt   <= '0;
      end else begin
         lvl_p1 <= lvl;
         for (int i = 0; i < 2; i++) begin
            if (raw_s[i] == lvl[i]) begin
               fcnt[i] <= 3'd0;
            end else if (fcnt[i] == FILT_M1) begin
               lvl[i]  <= raw_s[i];
               fcnt[i] <= 3'd0;
            end else begin
               fcnt[i] <= fcnt[i] + 3'd1;
            end
         end
      end
   end

   assign scl_f    = lvl[0];
   assign sda_f    = lvl[1];
   assign scl_rise = lvl[0] & ~lvl_p1[0];
   assign scl_fall = ~lvl[0] & lvl_p1[0];
   assign start_c  = lvl_p1[1] & ~lvl[1] & scl_f;
   assign stop_c   = ~lvl_p1[1] & lvl[1] & scl_f;
   assign rx_byte  = {shift[6:0], sda_f};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (stop_c) begin
         state_nxt = IDLE;
      end else if (start_c) begin
         state_nxt = ADDR;
      end else begin
         unique case (state)
            ADDR:     if (scl_rise && cnt == 3'd7)
                         state_nxt = (rx_byte[7:1] == TGT_ADDR) ? ACK_ADDR : IDLE;
            ACK_ADDR: if (scl_fall && ack_ph) state_nxt = rw ? RD : WR_PTR;
            WR_PTR:   if (scl_rise && cnt == 3'd7) state_nxt = ACK_PTR;
            ACK_PTR:  if (scl_fall && ack_ph) state_nxt = WR_DATA;
            WR_DATA:  if (scl_rise && cnt == 3'd7) state_nxt = ACK_DATA;
            ACK_DATA: if (scl_fall && ack_ph) state_nxt = WR_DATA;
            RD:       if (scl_fall && cnt == 3'd7) state_nxt = RD_ACK;
            RD_ACK:   if (scl_fall) state_nxt = mack_n ? WAIT_P : RD;
            default:  state_nxt = state;
         endcase
      end
   end

   always_comb begin
      logic ev_ok, in_ack;
      ev_ok     = !start_c && !stop_c;
      in_ack    = (state == ACK_ADDR) || (state == ACK_PTR) || (state == ACK_DATA);
      shift_in  = ev_ok && scl_rise &&
                  ((state == ADDR) || (state == WR_PTR) || (state == WR_DATA));
      ack_begin = ev_ok && scl_fall && in_ack && !ack_ph;
      ack_end   = ev_ok && scl_fall && in_ack && ack_ph;
      rd_load   = (ack_end && (state == ACK_ADDR) && rw) ||
                  (ev_ok && scl_fall && (state == RD_ACK) && !mack_n);
      rd_shift  = ev_ok && scl_fall && (state == RD) && (cnt != 3'd7);
      rd_done   = ev_ok && scl_fall && (state == RD) && (cnt == 3'd7);
      ptr_load  = shift_in && (state == WR_PTR) && (cnt == 3'd7);
      wr_strobe = shift_in && (state == WR_DATA) && (cnt == 3'd7);
      reg_re    = rd_load;
   end

   // Stage p2: shifter, bit counter, SDA drive and register-map interface
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift     <= '0;
         cnt       <= '0;
         ack_ph    <= 1'b0;
         rw        <= 1'b0;
         mack_n    <= 1'b1;
         sda_oe    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         reg_we <= wr_strobe;
         busy   <= (state_nxt != IDLE);
         if (reg_we || rd_done) reg_addr <= reg_addr + ADDR_ONE;
         if (start_c || stop_c) begin
            shift  <= '0;
            cnt    <= '0;
            ack_ph <= 1'b0;
            sda_oe <= 1'b0;
         end else begin
            if (shift_in) begin
               shift <= rx_byte;
               cnt   <= cnt + 3'd1;
            end
            if (shift_in && state == ADDR && cnt == 3'd7) rw <= sda_f;
            if (ptr_load)  reg_addr  <= REG_AW'(rx_byte);
            if (wr_strobe) reg_wdata <= rx_byte;
            if (ack_begin) begin
               sda_oe <= 1'b1;
               ack_ph <= 1'b1;
            end
            if (ack_end) begin
               sda_oe <= 1'b0;
               ack_ph <= 1'b0;
            end
            // The read load must win over the ACK release on the same fall
            if (rd_load) begin
               shift  <= reg_rdata;
               sda_oe <= ~reg_rdata[7];
            end
            if (rd_shift) begin
               shift  <= {shift[6:0], 1'b0};
               sda_oe <= ~shift[6];
               cnt    <= cnt + 3'd1;
            end
            if (rd_done) begin
               sda_oe <= 1'b0;
               cnt    <= cnt + 3'd1;
            end
            if (state == RD_ACK && scl_rise) mack_n <= sda_f;
         end
      end
   end

endmodule
